// File: rtl/lab3_p1_clk_pkg.sv
// Shared definitions for the system-PLL supervisor: FSM encoding, synchronizer
// depth and a helper used to size the shared cycle counter.
package lab3_p1_clk_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } pll_state_e;

    localparam int SYNC_STAGES = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lab3_p1_bit_sync.sv
// Single-bit multi-flop synchronizer; DEPTH must be at least 2.
module lab3_p1_bit_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sync_p0;

    // Shift the asynchronous input through DEPTH flops, clearing to 0 on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[DEPTH-2:0], din};
        end
    end

    assign dout = sync_p0[DEPTH-1];

endmodule

// File: rtl/lab3_p1_sys_clk_pll_supervisor.sv
// System PLL supervisor: pulses the PLL reset, qualifies a stable lock and then
// releases the downstream reset domains one at a time, re-arming on lock loss.
module lab3_p1_sys_clk_pll_supervisor
    import lab3_p1_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES     = 2,
    parameter int STAGE_GAP      = 256,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  all_ready,
    output logic [CNT_W-1:0]      lock_loss_count,
    output logic [CNT_W-1:0]      timeout_count,
    output logic [2:0]            state
);

    // The shared counter only ever has to reach the largest terminal value.
    localparam int MAX_CYC = max4(LOCK_TIMEOUT, STABLE_CYCLES, STAGE_GAP, PLL_RST_CYCLES);
    localparam int CYC_W   = $clog2(MAX_CYC);

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LAST    = CYC_W'(STAGE_GAP - 1);

    pll_state_e            state_q, state_d;
    logic [CYC_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_d, stage_step;
    logic [CNT_W-1:0]      loss_d, tmo_d;
    logic                  locked_s;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    lab3_p1_bit_sync #(
        .DEPTH (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pll_locked),
        .dout    (locked_s)
    );

    // Next-state logic: sw_reset_req beats lock loss, which beats timeout and progress.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CYC_W'(1);
        stage_d    = stage_reset_n;
        loss_d     = lock_loss_count;
        tmo_d      = timeout_count;
        stage_step = (stage_reset_n << 1) | NUM_STAGES'(1);

        if (sw_reset_req && (state_q != ST_PLL_RST)) begin
            state_d = ST_PLL_RST;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = ST_PLL_RST;
                        tmo_d   = sat_inc(timeout_count);
                    end
                end
                ST_STABLE: begin
                    // A drop before release is only a failed qualification, not a loss.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        stage_d = stage_step;
                        state_d = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        stage_d = '0;
                        loss_d  = sat_inc(lock_loss_count);
                    end else if (cnt_q == GAP_LAST) begin
                        stage_d = stage_step;
                        cnt_d   = '0;
                        if (&stage_step) state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        stage_d = '0;
                        loss_d  = sat_inc(lock_loss_count);
                    end
                end
                default: begin
                    state_d = ST_PLL_RST;
                    stage_d = '0;
                end
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
    end

    // Register state and every output so nothing combinational reaches a port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_PLL_RST;
            cnt_q           <= '0;
            pll_rst         <= 1'b1;
            stage_reset_n   <= '0;
            all_ready       <= 1'b0;
            lock_loss_count <= '0;
            timeout_count   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pll_rst         <= (state_d == ST_PLL_RST);
            stage_reset_n   <= stage_d;
            all_ready       <= (state_d == ST_RUN);
            lock_loss_count <= loss_d;
            timeout_count   <= tmo_d;
        end
    end

    assign state = state_q;

endmodule
